// File: rtl/mem_wb_regfile_pkg.sv
// Shared register-file constants and encodings for the MEM/WB stage and GPR file.
package mem_wb_regfile_pkg;

  localparam int RegDataW = 32;
  localparam int RegAddrW = 5;
  localparam int RegNum   = 32;

  typedef logic [RegAddrW-1:0] RegAddrBus;
  typedef logic [RegDataW-1:0] RegBus;

  localparam RegBus     ZeroWord     = '0;
  localparam RegAddrBus NOPRegAddr   = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      ReadDisable  = 1'b0;
  localparam logic      Stop         = 1'b1;
  localparam logic      NoStop       = 1'b0;

endpackage

// File: rtl/mem_wb_regfile_regfile.sv
// GPR file: r0 hard-wired to zero, one write port, two combinational read ports.
// Latency: write lands at the next edge; reads are combinational with bypass of the pending write.
// Backpressure: none; the write port is always accepted.
module regfile
  import mem_wb_regfile_pkg::*;
#(
  parameter int DATA_W   = RegDataW,
  parameter int ADDR_W   = RegAddrW,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we == WriteEnable && waddr != NOPRegAddr) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets decode see a WB result one cycle before it lands in the array.
  always_comb begin
    rdata1 = '0;
    if (!rst || re1 == ReadDisable || raddr1 == NOPRegAddr) rdata1 = '0;
    else if (raddr1 == waddr && we == WriteEnable)          rdata1 = wdata;
    else                                                    rdata1 = regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (!rst || re2 == ReadDisable || raddr2 == NOPRegAddr) rdata2 = '0;
    else if (raddr2 == waddr && we == WriteEnable)          rdata2 = wdata;
    else                                                    rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/mem_wb_regfile.sv
// MEM/WB pipeline register feeding the GPR file, with stall/flush priority.
// Latency: MEM triple appears on wb_* one edge later and commits to the GPRs one edge after that.
// Backpressure: wb_stall holds the WB triple; mem_stall alone inserts a bubble; flush always bubbles.
module mem_wb_regfile
  import mem_wb_regfile_pkg::*;
#(
  parameter int DATA_W   = RegDataW,
  parameter int ADDR_W   = RegAddrW,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              wb_stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  // flush wins over a WB hold so a redirect never lets a stale write survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd    <= '0;
      wb_wreg  <= WriteDisable;
      wb_wdata <= '0;
    end else if (flush || (mem_stall == Stop && wb_stall == NoStop)) begin
      wb_wd    <= '0;
      wb_wreg  <= WriteDisable;
      wb_wdata <= '0;
    end else if (wb_stall == NoStop) begin
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg;
      wb_wdata <= mem_wdata;
    end
  end

  regfile #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_wreg),
    .waddr (wb_wd),
    .wdata (wb_wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata2(rdata2)
  );

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Randomized scoreboard bench for mem_wb_regfile against an architectural reference model.
module tb_mem_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_stall, wb_stall, flush;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;

  mem_wb_regfile dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .wb_stall(wb_stall), .flush(flush),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Architectural model: 32 registers plus the one write sitting in WB.
  logic [31:0] gpr [32];
  logic [4:0]  m_wd;
  logic        m_we;
  logic [31:0] m_wdata;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    m_wd = 5'd0; m_we = 1'b0; m_wdata = 32'h0;
  endfunction

  function automatic void model_edge();
    if (m_we && m_wd != 5'd0) gpr[m_wd] = m_wdata;
    if (flush || (mem_stall && !wb_stall)) begin
      m_wd = 5'd0; m_we = 1'b0; m_wdata = 32'h0;
    end else if (!wb_stall) begin
      m_wd = mem_wd; m_we = mem_wreg; m_wdata = mem_wdata;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
    if (!rst || !en || a == 5'd0) return 32'h0;
    if (m_we && a == m_wd) return m_wdata;
    return gpr[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model takes the edge with the inputs that were held across it,
  // then new inputs are driven and the expected post-edge view is queued.
  task automatic cycle(input logic r, input logic [4:0] wd, input logic we, input logic [31:0] d,
                       input logic ms, input logic ws, input logic fl,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    if (rst) model_edge();
    #1;
    rst = r;
    if (!r) model_clear();
    mem_wd = wd; mem_wreg = we; mem_wdata = d;
    mem_stall = ms; wb_stall = ws; flush = fl;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    e.wd = m_wd; e.we = m_we; e.wdata = m_wdata;
    e.r1 = model_read(e1, a1);
    e.r2 = model_read(e2, a2);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wb_wd",    {27'h0, wb_wd}, {27'h0, e.wd});
      chk("wb_wreg",  {31'h0, wb_wreg}, {31'h0, e.we});
      chk("wb_wdata", wb_wdata, e.wdata);
      chk("rdata1",   rdata1, e.r1);
      chk("rdata2",   rdata2, e.r2);
    end
  end

  initial begin
    rst = 1'b0;
    mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'hA5A5A5A5;
    mem_stall = 1'b0; wb_stall = 1'b0; flush = 1'b0;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    model_clear();

    // Reset held with a valid write presented, then every register read back as zero.
    cycle(1'b0, 5'd3, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd4);
    for (int i = 0; i < 32; i += 2)
      cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 1'b1, 5'(i + 1));

    // Write to r5 observed through bypass, then from the array.
    cycle(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd5);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);

    // r0 writes never stick, even while in WB.
    cycle(1'b1, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);

    // MEM stall bubbles, WB stall holds, flush beats WB stall.
    cycle(1'b1, 5'd9, 1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd9);
    cycle(1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd6);
    cycle(1'b1, 5'd8, 1'b1, 32'h88, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd8);
    cycle(1'b1, 5'd7, 1'b1, 32'h77, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd7);
    cycle(1'b1, 5'd7, 1'b1, 32'h77, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd6);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd6);

    // Read enable gating on a known value.
    cycle(1'b1, 5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd5);
    cycle(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);

    // Random traffic on a narrow address range to provoke hits, stalls and occasional reset.
    for (int n = 0; n < 1500; n++) begin
      logic r;
      r = ($urandom_range(0, 199) != 0);
      cycle(r, 5'($urandom_range(0, 7)), 1'($urandom), $urandom,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
